// File: rtl/lcd_pkg.sv
// Shared geometry and state encoding for the LCD framebuffer capture path.
package lcd_pkg;

  localparam int unsigned H_ACTIVE       = 160;
  localparam int unsigned V_ACTIVE       = 144;
  localparam int unsigned WORDS_PER_LINE = 40;
  localparam int unsigned BANK_WORDS     = 5760;
  localparam int unsigned FB_ADDR_W      = 14;
  localparam int unsigned OFFS_W         = 13;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_CAPTURE = 1'b1;

endpackage

// File: rtl/lcd_edge_det.sv
// Registered rising-edge detector; rise is valid one cycle after the input edge.
module lcd_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic cur_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cur_q  <= d;
      prev_q <= cur_q;
    end
  end

  assign rise = cur_q & ~prev_q;

endmodule

// File: rtl/lcd_fb_capture.sv
// Packs the core LCD pixel stream four-per-byte into a double-buffered
// 160x144 framebuffer write port and tracks the last completed bank.
module lcd_fb_capture
  import lcd_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hs,
  input  logic                 vs,
  input  logic                 cpl,
  input  logic [1:0]           pixel,
  input  logic                 valid,
  output logic                 fb_we,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [7:0]           fb_wdata,
  output logic                 disp_bank,
  output logic                 frame_valid,
  output logic                 frame_done,
  output logic                 err_overrun,
  output logic                 err_short
);

  localparam logic [7:0]        H_MAX     = 8'(H_ACTIVE);
  localparam logic [7:0]        V_MAX     = 8'(V_ACTIVE);
  localparam logic [OFFS_W-1:0] LINE_STEP = OFFS_W'(WORDS_PER_LINE);

  logic hs_rise, vs_rise, cpl_rise;

  lcd_edge_det u_hs_det  (.clk(clk), .rst(rst), .d(hs),  .rise(hs_rise));
  lcd_edge_det u_vs_det  (.clk(clk), .rst(rst), .d(vs),  .rise(vs_rise));
  lcd_edge_det u_cpl_det (.clk(clk), .rst(rst), .d(cpl), .rise(cpl_rise));

  // pixel/valid are delayed one cycle so they line up with the detected cpl edge
  logic [1:0]        pixel_q;
  logic              valid_q;
  logic [0:0]        state_q;
  logic              wbank_q;
  logic [7:0]        x_q, y_q;
  logic [OFFS_W-1:0] line_base_q;
  logic [7:0]        pack_q;

  logic              px_ok, px_drop, word_full, flush;
  logic [7:0]        x_n;
  logic [1:0]        x_lsb_n;
  logic [7:0]        pack_n;
  logic [OFFS_W-1:0] wr_off;

  always_comb begin
    px_ok     = cpl_rise & valid_q & (x_q < H_MAX) & (y_q < V_MAX);
    px_drop   = cpl_rise & valid_q & ~((x_q < H_MAX) & (y_q < V_MAX));
    x_n       = x_q + {7'd0, px_ok};
    x_lsb_n   = x_q[1:0] + {1'b0, px_ok};
    word_full = px_ok & (x_q[1:0] == 2'd3);
    flush     = hs_rise & (x_lsb_n != 2'd0);
    pack_n    = pack_q;
    if (px_ok) pack_n[{x_q[1:0], 1'b0} +: 2] = pixel_q;
    // a completed or flushed word always belongs to the pre-increment x/4 slot
    wr_off    = line_base_q + {7'd0, x_q[7:2]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_q     <= '0;
      valid_q     <= 1'b0;
      state_q     <= ST_IDLE;
      wbank_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      line_base_q <= '0;
      pack_q      <= '0;
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_wdata    <= '0;
      disp_bank   <= 1'b0;
      frame_valid <= 1'b0;
      frame_done  <= 1'b0;
      err_overrun <= 1'b0;
      err_short   <= 1'b0;
    end else begin
      pixel_q    <= pixel;
      valid_q    <= valid;
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (vs_rise) begin
            state_q     <= ST_CAPTURE;
            x_q         <= '0;
            y_q         <= '0;
            line_base_q <= '0;
            pack_q      <= '0;
          end
        end
        default: begin
          if (vs_rise) begin
            if (y_q == V_MAX) begin
              frame_done  <= 1'b1;
              disp_bank   <= wbank_q;
              wbank_q     <= ~wbank_q;
              frame_valid <= 1'b1;
            end else begin
              err_short <= 1'b1;
            end
            x_q         <= '0;
            y_q         <= '0;
            line_base_q <= '0;
            pack_q      <= '0;
          end else begin
            if (px_drop) err_overrun <= 1'b1;
            if (word_full | flush) begin
              fb_we    <= 1'b1;
              fb_addr  <= {wbank_q, wr_off};
              fb_wdata <= pack_n;
            end
            if (hs_rise) begin
              x_q    <= '0;
              pack_q <= '0;
              if (y_q < V_MAX) begin
                y_q         <= y_q + 8'd1;
                line_base_q <= line_base_q + LINE_STEP;
              end else begin
                err_overrun <= 1'b1;
              end
            end else begin
              x_q    <= x_n;
              pack_q <= word_full ? '0 : pack_n;
            end
          end
        end
      endcase
    end
  end

endmodule
